// File: rtl/pipelined_adder.sv
// Carry-segmented add/subtract pipeline, NSEG+1 cycle latency, one result per cycle.
// A stalled output freezes every stage together; in_ready is the global advance.
module pipelined_adder #(
   parameter int ADDER_WIDTH = 152,
   parameter int SEG_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ADDER_WIDTH-1:0] a,
   input  logic [ADDER_WIDTH-1:0] b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDER_WIDTH:0]   sum
);

   localparam int NSEG = (ADDER_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;

   // Stage k (0..NSEG): operands, partial sum and the carry into segment k.
   logic                   vld_q [NSEG+1];
   logic                   vld_d [NSEG+1];
   logic [ADDER_WIDTH-1:0] opa_q [NSEG+1];
   logic [ADDER_WIDTH-1:0] opa_d [NSEG+1];
   logic [ADDER_WIDTH-1:0] opb_q [NSEG+1];
   logic [ADDER_WIDTH-1:0] opb_d [NSEG+1];
   logic [ADDER_WIDTH-1:0] psum_q [NSEG+1];
   logic [ADDER_WIDTH-1:0] psum_d [NSEG+1];
   logic                   cry_q [NSEG+1];
   logic                   cry_d [NSEG+1];

   logic                   adv;
   int                     seg_lo;
   int                     seg_w;
   logic [SEG_WIDTH-1:0]   seg_a;
   logic [SEG_WIDTH-1:0]   seg_b;
   logic [SEG_WIDTH:0]     seg_tot;
   logic [SEG_WIDTH:0]     seg_sh;
   logic [ADDER_WIDTH-1:0] seg_mask;

   assign adv       = out_ready | ~out_valid;
   assign in_ready  = adv;
   assign out_valid = vld_q[NSEG];
   assign sum       = {cry_q[NSEG], psum_q[NSEG]};

   always_comb begin
      seg_lo   = 0;
      seg_w    = 0;
      seg_a    = '0;
      seg_b    = '0;
      seg_tot  = '0;
      seg_sh   = '0;
      seg_mask = '0;
      for (int k = 0; k <= NSEG; k++) begin
         vld_d[k]  = vld_q[k];
         opa_d[k]  = opa_q[k];
         opb_d[k]  = opb_q[k];
         psum_d[k] = psum_q[k];
         cry_d[k]  = cry_q[k];
      end
      if (adv) begin
         // Subtraction is a + ~b + 1, so the inversion and carry-in happen at capture.
         vld_d[0]  = in_valid;
         opa_d[0]  = a;
         opb_d[0]  = sub ? ~b : b;
         psum_d[0] = '0;
         cry_d[0]  = sub;
         for (int k = 1; k <= NSEG; k++) begin
            seg_lo = (k - 1) * SEG_WIDTH;
            seg_w  = ADDER_WIDTH - seg_lo;
            if (seg_w > SEG_WIDTH) begin
               seg_w = SEG_WIDTH;
            end
            seg_a    = SEG_WIDTH'(opa_q[k-1] >> seg_lo);
            seg_b    = SEG_WIDTH'(opb_q[k-1] >> seg_lo);
            seg_tot  = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_WIDTH{1'b0}}, cry_q[k-1]};
            // A narrow top segment carries out at bit seg_w, not at bit SEG_WIDTH.
            seg_sh   = seg_tot >> seg_w;
            seg_mask = (ADDER_WIDTH'(1) << seg_w) - ADDER_WIDTH'(1);
            vld_d[k]  = vld_q[k-1];
            opa_d[k]  = opa_q[k-1];
            opb_d[k]  = opb_q[k-1];
            cry_d[k]  = seg_sh[0];
            psum_d[k] = psum_q[k-1] | ((ADDER_WIDTH'(seg_tot) & seg_mask) << seg_lo);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= NSEG; k++) begin
            vld_q[k]  <= 1'b0;
            opa_q[k]  <= '0;
            opb_q[k]  <= '0;
            psum_q[k] <= '0;
            cry_q[k]  <= 1'b0;
         end
      end else begin
         for (int k = 0; k <= NSEG; k++) begin
            vld_q[k]  <= vld_d[k];
            opa_q[k]  <= opa_d[k];
            opb_q[k]  <= opb_d[k];
            psum_q[k] <= psum_d[k];
            cry_q[k]  <= cry_d[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: default 152/32 instance plus 8-bit instances (3 segments and 1 segment).
module tb_pipelined_adder;

   localparam int W   = 152;
   localparam int LAT = 6;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] a         = '0;
   logic [W-1:0] b         = '0;
   logic         sub       = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W:0]   sum;

   logic [7:0]   a8   = '0;
   logic [7:0]   b8   = '0;
   logic         vld8 = 1'b0;
   logic         s1;
   logic         rdy8a, rdy8s, rdy1;
   logic         vo8a, vo8s, vo1;
   logic [8:0]   sum8a, sum8s, sum1;

   assign s1 = a8[0] ^ b8[3];

   always #5 clk = ~clk;

   pipelined_adder #(.ADDER_WIDTH(W), .SEG_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum));

   pipelined_adder #(.ADDER_WIDTH(8), .SEG_WIDTH(3)) u_add8 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy8a),
      .a(a8), .b(b8), .sub(1'b0), .out_valid(vo8a), .out_ready(1'b1), .sum(sum8a));

   pipelined_adder #(.ADDER_WIDTH(8), .SEG_WIDTH(3)) u_sub8 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy8s),
      .a(a8), .b(b8), .sub(1'b1), .out_valid(vo8s), .out_ready(1'b1), .sum(sum8s));

   pipelined_adder #(.ADDER_WIDTH(8), .SEG_WIDTH(8)) u_one8 (
      .clk(clk), .rst_n(rst_n), .in_valid(vld8), .in_ready(rdy1),
      .a(a8), .b(b8), .sub(s1), .out_valid(vo1), .out_ready(1'b1), .sum(sum1));

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %b, want %b", nm, $time, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [W:0] act, input logic [W:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
      logic [W-1:0] d;
      d = x - y;
      return s ? {(x >= y), d} : ({1'b0, x} + {1'b0, y});
   endfunction

   function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
      logic [7:0] d;
      d = x - y;
      return s ? {(x >= y), d} : ({1'b0, x} + {1'b0, y});
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [159:0] t;
      for (int k = 0; k < 5; k++) t[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         default: return t[W-1:0];
      endcase
   endfunction

   // Model: results queue in acceptance order; an entry reaches the output after LAT advances.
   typedef struct { logic [W:0] val; int stamp; } ent_t;
   typedef struct { logic [8:0] add; logic [8:0] dif; logic [8:0] one; int cyc; } e8_t;
   ent_t q[$];
   e8_t  q8[$];
   e8_t  q1[$];
   ent_t e;
   e8_t  e8;
   int   adv_cnt = 0;
   int   cyc     = 0;
   int   n_hs    = 0;
   logic m_vld, m8, m1;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         q8.delete();
         q1.delete();
         chk1("rst_out_valid", out_valid, 1'b0);
         chkw("rst_sum", sum, '0);
      end else begin
         m_vld = (q.size() > 0) && ((adv_cnt - q[0].stamp) == LAT);
         chk1("out_valid", out_valid, m_vld);
         chk1("in_ready", in_ready, out_ready | ~m_vld);
         if (m_vld) chkw("sum", sum, q[0].val);
         if (out_valid && out_ready) n_hs++;
         if (out_ready || !m_vld) begin
            if (m_vld) void'(q.pop_front());
            if (in_valid) begin
               e.val   = ref_result(a, b, sub);
               e.stamp = adv_cnt;
               q.push_back(e);
            end
            adv_cnt++;
         end

         chk1("small_ready", rdy8a & rdy8s & rdy1, 1'b1);
         m8 = (q8.size() > 0) && (q8[0].cyc == cyc - 4);
         m1 = (q1.size() > 0) && (q1[0].cyc == cyc - 2);
         chk1("add8_valid", vo8a, m8);
         chk1("sub8_valid", vo8s, m8);
         chk1("one8_valid", vo1, m1);
         if (m8) begin
            chkw("add8_sum", (W+1)'(sum8a), (W+1)'(q8[0].add));
            chkw("sub8_sum", (W+1)'(sum8s), (W+1)'(q8[0].dif));
            void'(q8.pop_front());
         end
         if (m1) begin
            chkw("one8_sum", (W+1)'(sum1), (W+1)'(q1[0].one));
            void'(q1.pop_front());
         end
         if (vld8) begin
            e8.add = ref8(a8, b8, 1'b0);
            e8.dif = ref8(a8, b8, 1'b1);
            e8.one = ref8(a8, b8, s1);
            e8.cyc = cyc;
            q8.push_back(e8);
            q1.push_back(e8);
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [W:0] exp_v;
   int         hs0;
   int         waited;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk1("reset_out_valid", out_valid, 1'b0);
      chkw("reset_sum", sum, '0);
      chk1("reset_in_ready", in_ready, 1'b1);

      // Release with operands already valid: first edge out of reset accepts.
      rst_n = 1'b1; in_valid = 1'b1; a = '1; b = W'(1); sub = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      chk1("ripple_lat5_valid", out_valid, 1'b0);
      step();
      chk1("ripple_lat6_valid", out_valid, 1'b1);
      exp_v = '0; exp_v[W] = 1'b1;
      chkw("ripple_sum", sum, exp_v);
      step();

      in_valid = 1'b1; a = W'(5); b = W'(7); sub = 1'b1;
      step();
      a = W'(7); b = W'(5);
      step();
      in_valid = 1'b0; sub = 1'b0;
      repeat (4) step();
      exp_v = {1'b0, {W{1'b1}}}; exp_v[0] = 1'b0;
      chkw("sub_borrow", sum, exp_v);
      step();
      exp_v = '0; exp_v[W] = 1'b1; exp_v[1] = 1'b1;
      chkw("sub_no_borrow", sum, exp_v);
      repeat (3) step();

      in_valid = 1'b1; a = W'(1); b = W'(2);
      step();
      a = W'(3); b = W'(4);
      step();
      a = '0; a[W-1] = 1'b1; b = a;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      chkw("b2b_first", sum, (W+1)'(3));
      step();
      chkw("b2b_second", sum, (W+1)'(7));
      step();
      exp_v = '0; exp_v[W] = 1'b1;
      chkw("b2b_third", sum, exp_v);
      repeat (8) step();

      // Backpressure: six fill the pipe, the seventh waits behind a held result.
      hs0 = n_hs;
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; a = W'(i + 10); b = W'(3 * i); sub = i[0];
         waited = 0;
         while (!in_ready && waited < 40) begin
            step();
            waited++;
         end
         if (waited >= 40) chk1("bp_accept_timeout", in_ready, 1'b1);
         step();
      end
      a = W'(16); b = W'(18); sub = 1'b0;
      chk1("bp_out_valid", out_valid, 1'b1);
      chk1("bp_in_ready_low", in_ready, 1'b0);
      for (int i = 0; i < 10; i++) begin
         step();
         chk1("hold_valid", out_valid, 1'b1);
         chk1("hold_in_ready", in_ready, 1'b0);
         chkw("hold_sum", sum, (W+1)'(10));
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (12) step();
      chkw("bp_result_count", (W+1)'(n_hs - hs0), (W+1)'(7));

      // Reset with one result stalled at the output and one operation in flight.
      out_ready = 1'b0;
      in_valid = 1'b1; a = W'(3); b = W'(4); sub = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      in_valid = 1'b1; a = W'(1); b = W'(1);
      step();
      in_valid = 1'b0;
      repeat (2) step();
      chkw("pre_reset_sum", sum, (W+1)'(7));
      rst_n = 1'b0;
      #1;
      chk1("async_rst_valid", out_valid, 1'b0);
      chkw("async_rst_sum", sum, '0);
      repeat (2) step();
      rst_n = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk1("post_reset_no_valid", out_valid, 1'b0);
      end

      for (int i = 0; i < 300; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a = rand_op(); b = rand_op(); sub = 1'($urandom_range(0, 1));
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) step();

      for (int i = 0; i < 65536; i++) begin
         vld8 = 1'b1; a8 = i[15:8]; b8 = i[7:0];
         step();
      end
      vld8 = 1'b0;
      repeat (8) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
